// File: rtl/sipo_deframer.sv
// MSB-first serial-to-parallel deframer with registered valid/ready output and overrun flag.
// Optional even-parity bit after the LSB is compiled in with SIPO_DEFRAMER_PARITY_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for frame_start, serial_in ignored
// S_SHIFT  | capturing data bits, cnt = bits captured so far
// S_PARITY | capturing the trailing parity bit (parity build only)
module sipo_deframer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef SIPO_DEFRAMER_PARITY_EN
        S_PARITY = 2'd2,
`endif
        S_SHIFT  = 2'd1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic             last_bit;
    logic             complete;
    logic [WIDTH-1:0] word;
    logic             word_perr;
    logic             out_free;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign out_free = !data_valid || data_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // frame_start always wins: it restarts a frame from any state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (frame_start) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (frame_start) begin
                    state_nxt = S_SHIFT;
                end else if (last_bit) begin
`ifdef SIPO_DEFRAMER_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
`ifdef SIPO_DEFRAMER_PARITY_EN
            S_PARITY: begin
                state_nxt = frame_start ? S_SHIFT : S_IDLE;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        complete  = 1'b0;
        word      = {sr[WIDTH-2:0], serial_in};
        word_perr = 1'b0;
`ifdef SIPO_DEFRAMER_PARITY_EN
        if (state == S_PARITY && !frame_start) begin
            complete  = 1'b1;
            word      = sr;
            word_perr = ^{sr, serial_in};
        end
`else
        if (state == S_SHIFT && !frame_start && last_bit) begin
            complete = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (frame_start) begin
            sr  <= {{(WIDTH-1){1'b0}}, serial_in};
            cnt <= CW'(1);
        end else begin
            if (state == S_SHIFT) sr <= {sr[WIDTH-2:0], serial_in};
            cnt <= (state_nxt == S_IDLE) ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= complete && !out_free;
            if (complete && out_free) begin
                data_out   <= word;
                data_valid <= 1'b1;
                parity_err <= word_perr;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: directed scenarios plus random traffic, checked each cycle
// against a frame-level model built on a bit queue.
`timescale 1ns/1ps
module tb_sipo_deframer;

    localparam int W = 4;
`ifdef SIPO_DEFRAMER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frame_start = 1'b0;
    logic         serial_in = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         data_ready = 1'b0;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    int n_total = 0;
    int n_bad   = 0;

    bit           m_active;
    logic         m_q[$];
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_busy;
    logic         m_ovr;
    logic         m_perr;

    sipo_deframer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("data_out",   32'(data_out),   32'(m_data));
        check("data_valid", 32'(data_valid), 32'(m_valid));
        check("busy",       32'(busy),       32'(m_busy));
        check("overrun",    32'(overrun),    32'(m_ovr));
        check("parity_err", 32'(parity_err), 32'(m_perr));
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_q.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_busy  = 1'b0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
    endtask

    // One clock edge of the frame-level behaviour
    task automatic model_edge(input logic fs, input logic sin, input logic rdy);
        bit           done = 1'b0;
        logic [W-1:0] wd = '0;
        logic         px = 1'b0;
        if (fs) begin
            m_q.delete();
            m_q.push_back(sin);
            m_active = 1'b1;
        end else if (m_active) begin
            m_q.push_back(sin);
            if (m_q.size() == FL) begin
                done = 1'b1;
                m_active = 1'b0;
            end
        end
        m_ovr = 1'b0;
        if (done) begin
            for (int i = 0; i < W; i++) wd = (wd << 1) | W'(m_q[i]);
            for (int i = 0; i < FL; i++) px = px ^ m_q[i];
            if (!m_valid || rdy) begin
                m_data  = wd;
                m_valid = 1'b1;
`ifdef SIPO_DEFRAMER_PARITY_EN
                m_perr  = px;
`else
                m_perr  = 1'b0;
`endif
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        m_busy = m_active;
    endtask

    // Entered and left at a falling edge
    task automatic step(input logic fs, input logic sin, input logic rdy);
        frame_start = fs;
        serial_in   = sin;
        data_ready  = rdy;
        @(posedge clk);
        model_edge(fs, sin, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send_frame(input logic [W-1:0] wd, input logic pbit, input logic rdy);
        for (int i = W - 1; i >= 0; i--) step(i == W - 1, wd[i], rdy);
`ifdef SIPO_DEFRAMER_PARITY_EN
        step(1'b0, pbit, rdy);
`else
        if (pbit === 1'bx) $display("note: unknown parity bit ignored");
`endif
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), rdy);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // single frame, then consume
        send_frame(4'hB, 1'b1, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);

        // back-to-back with a ready consumer
        send_frame(4'hB, 1'b1, 1'b1);
        send_frame(4'h6, 1'b0, 1'b1);
        idle(3, 1'b1);

        // overrun: second word arrives while first is still held
        send_frame(4'hB, 1'b1, 1'b0);
        send_frame(4'h6, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // resync after two bits
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        send_frame(4'h5, 1'b0, 1'b0);
        idle(2, 1'b1);

        // async reset during bit 3, with a pending word held
        send_frame(4'hB, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        frame_start = 1'b0;
        serial_in   = 1'b1;
        rst         = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        check_outputs();
        send_frame(4'h9, 1'b0, 1'b0);
        idle(2, 1'b1);

        // good and bad parity (parity bit ignored in the plain build)
        send_frame(4'hB, 1'b1, 1'b1);
        send_frame(4'hB, 1'b0, 1'b1);
        idle(2, 1'b1);

        // random traffic: gaps, resyncs, stalled and eager consumers
        for (int c = 0; c < 3000; c++) begin
            logic fs;
            logic rdy;
            if (!m_active) fs = 1'($urandom_range(0, 1));
            else           fs = ($urandom_range(0, 15) == 0);
            if (c < 1500) rdy = ($urandom_range(0, 3) != 0);
            else          rdy = ($urandom_range(0, 3) == 0);
            step(fs, 1'($urandom_range(0, 1)), rdy);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sipo_deframer.md
# sipo_deframer

Serial-in parallel-out deframer that sits directly downstream of the parallel-to-serial shifter. It receives an MSB-first serial stream with a frame-start strobe and reassembles WIDTH-bit words. Each completed word is presented on a registered parallel port with a valid/ready handshake. A word that completes while the output register is still full is dropped and flagged as an overrun.

## Interface
- `WIDTH`, default 4: data bits per frame; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high; clock clk.
- `frame_start`  in  1  high in the same cycle the MSB of a frame is on `serial_in`.
- `serial_in`  in  1  serial data, MSB first, one bit per cycle, no gaps inside a frame.
- `data_out`  out  WIDTH  completed word; held stable while `data_valid`=1.
- `data_valid`  out  1  output register holds an unconsumed word.
- `data_ready`  in  1  consumer accepts `data_out` on a clock edge where `data_valid`=1.
- `busy`  out  1  a frame is partially received.
- `overrun`  out  1  one-cycle pulse: a completed word was dropped.
- `parity_err`  out  1  parity result for the word in `data_out`; tied 0 without parity.

## Operation
- The FSM has three states: IDLE, SHIFT, and PARITY (PARITY exists only when parity is compiled in).
- A bit counter `cnt` holds the number of bits captured so far. Its width is clog2(WIDTH)+1.
- **IDLE:**
  - `frame_start`=1 captures `serial_in` as the MSB, sets `cnt`=1, and moves to SHIFT.
  - Otherwise the block stays in IDLE, and `serial_in` is ignored.
- **SHIFT:** each cycle the shift register takes `{sr[WIDTH-2:0], serial_in}` and `cnt` increments.
  - When the captured bit is bit index WIDTH-1 (`cnt`=WIDTH-1 before the edge), the word is complete.
  - Without parity, the block delivers the word and goes to IDLE.
  - With parity, it goes to PARITY.
- **PARITY:** samples `serial_in` as the parity bit, delivers the word, and goes to IDLE.
- **Delivery:** at the completion edge, the block checks whether the output register is free.
  - The register is free if `data_valid`=0, or if `data_valid`=1 and `data_ready`=1 at that same edge.
  - If free: `data_out` gets the assembled word, `data_valid` is 1, and `parity_err` is updated.
  - If not free: the new word is discarded, `data_out` and `data_valid` are unchanged, and `overrun` pulses.
- **Handshake:** `data_valid` falls on an edge where `data_valid`=1, `data_ready`=1, and no new word is delivered.
  - `data_ready` has no effect while `data_valid`=0.
- **Resync:** `frame_start`=1 while in SHIFT or PARITY aborts the partial frame without any flag.
  - That cycle's `serial_in` becomes the new MSB, `cnt`=1, and the state is SHIFT.
- `busy` = (state != IDLE).

## Timing
- **Reset values:** `data_out`=0, `data_valid`=0, `busy`=0, `overrun`=0, `parity_err`=0. Internally: state IDLE, `cnt`=0, shift register 0.
- **Reset mid-frame:** the partial word is discarded with no `overrun`. A pending `data_out` is also cleared.
- **Latency:** `data_valid` is high in the cycle after the LSB is sampled. With parity, it is the cycle after the parity bit.
- **Throughput:** one word per WIDTH cycles (WIDTH+1 with parity).
  - `frame_start` is legal in the first cycle after the completion edge, so back-to-back frames need zero idle cycles.
- **Upstream pairing:** the upstream shifter presents its MSB the cycle after its load. Therefore `frame_start` is the load strobe delayed by one register.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `SIPO_DEFRAMER_PARITY_EN`.
- **Defined:**
  - Each frame carries one extra bit after the LSB.
  - Even parity applies over the WIDTH data bits plus the parity bit.
  - `parity_err`=1 if the XOR of those WIDTH+1 bits is 1. It is registered together with `data_out`.
  - A parity error does not suppress delivery.
- **Undefined:**
  - Frames are exactly WIDTH bits and the PARITY state is not present.
  - `parity_err` is constant 0.

## Test plan
- **Single frame:** WIDTH=4, `frame_start` with bits 1,0,1,1, `data_ready`=0.
  - Response: `data_out`=4'hB and `data_valid`=1 in cycle 5.
  - `data_valid` drops one cycle after `data_ready`=1.
- **Back-to-back frames:** 4'hB then 4'h6 with no gap, `data_ready`=1 constantly.
  - Response: 4'hB is valid at cycle 5 and 4'h6 at cycle 9.
  - `data_valid` stays high continuously, with no `overrun`.
- **Overrun:** 4'hB completes and is not consumed, then 4'h6 completes with `data_ready`=0.
  - Response: `data_out` stays 4'hB and `overrun` pulses exactly one cycle.
- **Resync:** `frame_start`, bits 1,1, then `frame_start` again with 0,1,0,1.
  - Response: `data_out`=4'h5, no `overrun`, and `busy` stays continuous.
- **Reset during bit 3 of a frame:**
  - Response: all outputs go to 0 immediately.
  - The next frame 4'h9 decodes correctly.
- **Parity (with macro defined):**
  - 4'hB with parity bit 1 gives `parity_err`=0.
  - 4'hB with parity bit 0 gives `parity_err`=1, and `data_out` is still 4'hB.
